// File: rtl/koggestone_adder4.sv
`default_nettype none
// ============================================================================
// Module      : koggestone_adder4
// Description : Registered unsigned adder with a Kogge-Stone carry network.
// Revision    : 1.0
// ============================================================================
module koggestone_adder4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int c_LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] w_p_bit;
    logic [WIDTH-1:0] w_g_cur;
    logic [WIDTH-1:0] w_p_cur;
    logic [WIDTH-1:0] w_g_nxt;
    logic [WIDTH-1:0] w_p_nxt;
    logic [WIDTH-1:0] w_g_final;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_p_bit = a ^ b;

    // Prefix levels: each level merges with the group 2^k bits below.
    always_comb begin
        w_g_cur = a & b;
        w_p_cur = w_p_bit;
        w_g_nxt = w_g_cur;
        w_p_nxt = w_p_cur;
        for (int k = 0; k < c_LEVELS; k++) begin
            w_g_nxt = w_g_cur;
            w_p_nxt = w_p_cur;
            for (int i = (1 << k); i < WIDTH; i++) begin
                w_g_nxt[i] = w_g_cur[i] | (w_p_cur[i] & w_g_cur[i - (1 << k)]);
                w_p_nxt[i] = w_p_cur[i] & w_p_cur[i - (1 << k)];
            end
            w_g_cur = w_g_nxt;
            w_p_cur = w_p_nxt;
        end
        w_g_final = w_g_cur;
    end

    // No carry-in: carry into bit 0 is zero, carry into bit i+1 is group G[i:0].
    assign w_carry = {w_g_final[WIDTH-2:0], 1'b0};
    assign w_sum   = w_p_bit ^ w_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            sum       <= w_sum;
            carry_out <= w_g_final[WIDTH-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_koggestone_adder4.sv
`default_nettype none
// ============================================================================
// Module      : tb_koggestone_adder4
// Description : Self-checking bench for koggestone_adder4 against a+b.
// Revision    : 1.0
// ============================================================================
module tb_koggestone_adder4;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    int total = 0;
    int bad   = 0;

    koggestone_adder4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full-width unsigned sum of the operands.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp_v;
    logic [WIDTH:0] prev;
    logic [3:0]     sa [4];
    logic [3:0]     sb [4];
    logic [4:0]     sexp [4];

    initial begin
        rst = 1'b1;
        a   = 4'hF;
        b   = 4'hF;
        #1;
        check("reset_async", {carry_out, sum}, 5'h00);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("reset_held", {carry_out, sum}, 5'h00);
        end
        rst = 1'b0;
        tick();
        check("reset_release", {carry_out, sum}, 5'h1E);

        // Latency: outputs hold until the edge after sampling.
        a = 4'd3; b = 4'd5;
        tick();
        check("basic_3p5", {carry_out, sum}, 5'h08);
        a = 4'd2; b = 4'd2;
        #3;
        check("hold_before_edge", {carry_out, sum}, 5'h08);
        tick();
        check("basic_2p2", {carry_out, sum}, 5'h04);

        a = 4'hF; b = 4'h1;
        tick();
        check("carry_f_p1", {carry_out, sum}, 5'h10);
        a = 4'h8; b = 4'h8;
        tick();
        check("carry_8_p8", {carry_out, sum}, 5'h10);

        sa[0] = 4'd1;  sb[0] = 4'd2;  sexp[0] = 5'h03;
        sa[1] = 4'd7;  sb[1] = 4'd9;  sexp[1] = 5'h10;
        sa[2] = 4'd0;  sb[2] = 4'd0;  sexp[2] = 5'h00;
        sa[3] = 4'd15; sb[3] = 4'd15; sexp[3] = 5'h1E;
        for (int n = 0; n < 4; n++) begin
            a = sa[n]; b = sb[n];
            tick();
            check($sformatf("stream_%0d", n), {carry_out, sum}, sexp[n]);
        end

        // Exhaustive sweep, one pair per cycle.
        for (int n = 0; n < 256; n++) begin
            a = n[7:4]; b = n[3:0];
            tick();
            check($sformatf("exh_%0d_%0d", n[7:4], n[3:0]), {carry_out, sum}, ref_add(n[7:4], n[3:0]));
        end

        // Random back-to-back stream, scoreboard holds one pending result.
        exp_q.delete();
        for (int n = 0; n < 200; n++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            exp_q.push_back(ref_add(a, b));
            tick();
            exp_v = exp_q.pop_front();
            check("random", {carry_out, sum}, exp_v);
        end

        // Asynchronous reset between edges while the output is nonzero.
        a = 4'd9; b = 4'd9;
        tick();
        check("pre_midreset", {carry_out, sum}, 5'h12);
        a = 4'd6; b = 4'd7;
        #2;
        rst = 1'b1;
        #1;
        check("midreset_async_clear", {carry_out, sum}, 5'h00);
        tick();
        check("midreset_held", {carry_out, sum}, 5'h00);
        #2;
        rst = 1'b0;
        a = 4'd12; b = 4'd5;
        tick();
        check("after_release", {carry_out, sum}, ref_add(4'd12, 4'd5));
        prev = {carry_out, sum};
        a = 4'd4; b = 4'd11;
        tick();
        check("after_release_2", {carry_out, sum}, ref_add(4'd4, 4'd11));
        check("after_release_changed", {carry_out, sum} ^ prev, 5'h11 ^ 5'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/koggestone_adder4.md
Name: koggestone_adder4

Overview:
- Registered 4-bit unsigned adder built on a Kogge-Stone parallel-prefix carry network; no carry-in.
- Operands are sampled on every rising clock edge; the registered sum and carry-out appear one cycle later.
- Standalone arithmetic macro (Tiny Tapeout user project slot); drives no other on-chip logic.

Parameters:
- WIDTH, 4, operand/sum width. Must be a power of two ≥ 2. Prefix depth is log2(WIDTH), which is 2 levels at the default.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- sum  output  WIDTH  registered (a+b) mod 2^WIDTH
- carry_out  output  1  registered carry out of the MSB

Behaviour:
- Interface decision (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset:
  - While rst=1, sum=0 and carry_out=0 immediately, independent of clk.
  - Release is sampled at the next rising clk edge.
- Carry network is purely combinational, structured as Kogge-Stone:
  - Bit level: g_i = a_i & b_i; p_i = a_i ^ b_i.
  - Level k, distance d = 2^(k-1):
    - For i ≥ d: G_i ← G_i | (P_i & G_(i-d)); P_i ← P_i & P_(i-d).
    - For i < d: G_i and P_i pass through unchanged.
  - Carries: c_0 = 0; c_(i+1) = final G_i.
  - Sum: s_i = p_i ^ c_i; carry_out_next = c_WIDTH.
- Register stage:
  - On each rising clk edge with rst=0: sum ← s, carry_out ← c_WIDTH.
  - Latency is exactly 1 cycle from the sampling edge; throughput is one addition per cycle.
  - There is no handshake and no enable; outputs update every cycle.
- Arithmetic:
  - {carry_out, sum} equals the full WIDTH+1-bit unsigned sum a+b.
  - Overflow wraps sum modulo 2^WIDTH, with carry_out=1.
- Inputs that change between edges have no effect until the next edge. Outputs are glitch-free because they are registered.
- Reset asserted mid-stream:
  - Outputs clear asynchronously and the pending result is discarded.
  - The first valid output after release reflects the operands sampled at the first edge with rst=0.
- X on inputs need not be handled; the bench drives known values only.

Test Plan:
- Reset: assert rst with a=4'hF, b=4'hF and toggle clk → sum=0, carry_out=0 throughout. Deassert and clock once → sum=4'hE, carry_out=1.
- Basic and latency: a=3, b=5 at edge N → at edge N+1, sum=8, carry_out=0. Before edge N+1 the outputs still hold the previous result.
- Full carry propagation: a=4'hF, b=1 → sum=0, carry_out=1. Also a=4'h8, b=4'h8 → sum=0, carry_out=1.
- Pipelined stream: apply (1,2), (7,9), (0,0), (15,15) on consecutive edges → outputs on the following edges are (3,0), (0,1), (0,0), (14,1) as (sum, carry_out).
- Exhaustive: all 256 (a,b) pairs, one per cycle → every {carry_out,sum} equals a+b one cycle later.
- Async reset mid-stream: raise rst between edges while sum is nonzero → outputs go to 0 before the next edge. After release, results resume correctly.
